// File: rtl/tlb_random_gen.sv
// -----------------------------------------------------------------------------
// tlb_random_gen
//
// Replacement-index generator for the CP0 Random register. It owns the Wired
// register and produces the TLBWR victim index, always kept inside
// [Wired, ENTRIES-1].
//
// Index update modes (mode input):
//   0 : LCG pseudo-random; a new index is drawn on each `next` pulse
//   1 : round-robin; the index is decremented (with wrap) on each `next` pulse
//   2 : free-running; the index is decremented (with wrap) every cycle,
//       and `next` is ignored
//   3 : reserved; behaves exactly like mode 0
//
// Handshake: there is no valid/ready pairing in this block. `next`,
// `wiredWe` and `seedWe` are single-cycle strobes, sampled on the rising
// clock edge. Their effect shows on the registered outputs one cycle later.
//
// Ports:
//   clk        in   1        clock
//   rst        in   1        synchronous active-high reset
//   mode       in   2        index update mode (see above)
//   next       in   1        TLBWR commit pulse; advances the index
//   wiredWe    in   1        write the Wired register
//   wiredIn    in   IDX_W    new Wired value
//   seedWe     in   1        load the LCG state
//   seedIn     in   PRNG_W   new LCG state
//   regWired   out  IDX_W    Wired register
//   regRandom  out  IDX_W    Random register (TLBWR victim index)
// -----------------------------------------------------------------------------
module tlb_random_gen #(
    parameter int                ENTRIES = 32,
    parameter int                IDX_W   = $clog2(ENTRIES),
    parameter int                PRNG_W  = 18,
    parameter int unsigned       LCG_MUL = 65521,
    parameter int unsigned       LCG_INC = 1,
    parameter logic [PRNG_W-1:0] SEED    = 18'h143fd
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              next,
    input  logic              wiredWe,
    input  logic [IDX_W-1:0]  wiredIn,
    input  logic              seedWe,
    input  logic [PRNG_W-1:0] seedIn,
    output logic [IDX_W-1:0]  regWired,
    output logic [IDX_W-1:0]  regRandom
);

    // The product is wide enough to hold prng * range without truncation.
    localparam int PROD_W = PRNG_W + IDX_W + 1;

    localparam logic [IDX_W:0]    ENTRIES_V = (IDX_W + 1)'(ENTRIES);
    localparam logic [IDX_W-1:0]  MAX_IDX   = IDX_W'(ENTRIES - 1);
    localparam logic [PRNG_W-1:0] MUL_V     = PRNG_W'(LCG_MUL);
    localparam logic [PRNG_W-1:0] INC_V     = PRNG_W'(LCG_INC);

    logic [IDX_W-1:0]  random_q, random_d;
    logic [IDX_W-1:0]  wired_q,  wired_d;
    logic [PRNG_W-1:0] prng_q,   prng_d;

    logic              lcg_mode;
    logic              rr_mode;
    logic              fr_mode;
    logic [IDX_W:0]    range_w;
    logic [PROD_W-1:0] product;
    logic [IDX_W-1:0]  lcg_idx;
    logic [IDX_W-1:0]  dec_idx;
    logic [PRNG_W-1:0] prng_step;

    always_comb begin
        lcg_mode = (mode == 2'd0) || (mode == 2'd3);
        rr_mode  = (mode == 2'd1);
        fr_mode  = (mode == 2'd2);

        // range is at least 1 because Wired never exceeds ENTRIES-1.
        range_w = ENTRIES_V - {1'b0, wired_q};

        // Scale the PRNG state into [0, range-1]. Since prng < 2^PRNG_W,
        // (prng * range) >> PRNG_W < range, so the sum stays <= ENTRIES-1.
        product = {{(IDX_W + 1){1'b0}}, prng_q} * {{PRNG_W{1'b0}}, range_w};
        lcg_idx = wired_q + IDX_W'(product >> PRNG_W);

        // Decrement, wrapping back to the top once Wired is reached.
        dec_idx = (random_q == wired_q) ? MAX_IDX : (random_q - 1'b1);

        // The multiply is done at PRNG_W bits, which gives the mod 2^PRNG_W.
        prng_step = (MUL_V * prng_q) + INC_V;
    end

    always_comb begin
        wired_d  = wired_q;
        random_d = random_q;
        prng_d   = prng_q;

        // Index: wiredWe wins over any stepping in the same cycle.
        if (wiredWe) begin
            wired_d  = wiredIn;
            random_d = MAX_IDX;
        end else if (lcg_mode && next) begin
            random_d = lcg_idx;
        end else if ((rr_mode && next) || fr_mode) begin
            random_d = dec_idx;
        end

        // PRNG: a seed load replaces the step. A coincident next has already
        // drawn its index from the old state above.
        if (seedWe) begin
            prng_d = seedIn;
        end else if (lcg_mode && next) begin
            prng_d = prng_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wired_q  <= '0;
            random_q <= MAX_IDX;
            prng_q   <= SEED;
        end else begin
            wired_q  <= wired_d;
            random_q <= random_d;
            prng_q   <= prng_d;
        end
    end

    assign regWired  = wired_q;
    assign regRandom = random_q;

endmodule

// File: tb/tb_tlb_random_gen.sv
// -----------------------------------------------------------------------------
// tb_tlb_random_gen
//
// Bench for tlb_random_gen. It drives three instances (ENTRIES = 8, 32 and
// 64) from shared stimulus. The directed scenarios check the 32-entry
// instance against known values. A behavioural model of all three instances
// is updated on every clock edge, and the random run compares every instance
// against it and also checks the range invariant.
// -----------------------------------------------------------------------------
module tb_tlb_random_gen;

  localparam int PRNG_W = 18;
  localparam longint SEED_V = 64'h143fd;
  localparam longint MOD_V  = 64'd262144;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              next;
  logic              wired_we;
  logic [5:0]        wired_in_w;
  logic              seed_we;
  logic [PRNG_W-1:0] seed_in;

  logic [2:0] wired_8,  random_8;
  logic [4:0] wired_32, random_32;
  logic [5:0] wired_64, random_64;

  int checks = 0;
  int errors = 0;

  // behavioural model state, one slot per instance
  int     ent [3] = '{8, 32, 64};
  int     m_rand [3];
  int     m_wired [3];
  longint m_prng [3];

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  tlb_random_gen #(.ENTRIES(8)) u_dut8 (
    .clk(clk), .rst(rst), .mode(mode), .next(next),
    .wiredWe(wired_we), .wiredIn(wired_in_w[2:0]),
    .seedWe(seed_we), .seedIn(seed_in),
    .regWired(wired_8), .regRandom(random_8)
  );

  tlb_random_gen #(.ENTRIES(32)) u_dut32 (
    .clk(clk), .rst(rst), .mode(mode), .next(next),
    .wiredWe(wired_we), .wiredIn(wired_in_w[4:0]),
    .seedWe(seed_we), .seedIn(seed_in),
    .regWired(wired_32), .regRandom(random_32)
  );

  tlb_random_gen #(.ENTRIES(64)) u_dut64 (
    .clk(clk), .rst(rst), .mode(mode), .next(next),
    .wiredWe(wired_we), .wiredIn(wired_in_w[5:0]),
    .seedWe(seed_we), .seedIn(seed_in),
    .regWired(wired_64), .regRandom(random_64)
  );

  // --------------------------------------------------------------- model
  // Applies the register rules to the inputs present at the active edge.
  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      int     e;
      int     old_rand;
      int     old_wired;
      longint old_prng;
      bit     lcg;
      e         = ent[i];
      old_rand  = m_rand[i];
      old_wired = m_wired[i];
      old_prng  = m_prng[i];
      lcg       = (mode == 2'd0) || (mode == 2'd3);
      if (rst) begin
        m_rand[i]  = e - 1;
        m_wired[i] = 0;
        m_prng[i]  = SEED_V;
      end else begin
        if (wired_we) begin
          m_wired[i] = int'(wired_in_w) % e;
          m_rand[i]  = e - 1;
        end else if (lcg && next) begin
          m_rand[i] = old_wired + int'((old_prng * longint'(e - old_wired)) / MOD_V);
        end else if ((mode == 2'd1 && next) || mode == 2'd2) begin
          m_rand[i] = (old_rand == old_wired) ? e - 1 : old_rand - 1;
        end
        if (seed_we)
          m_prng[i] = longint'(seed_in);
        else if (lcg && next)
          m_prng[i] = (65521 * old_prng + 1) % MOD_V;
      end
    end
  endtask

  // One clock: the model follows the DUT edge, and the task returns on the
  // falling edge, where outputs are sampled and inputs are changed.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic int dut_rand(int i);
    return (i == 0) ? int'(random_8) : (i == 1) ? int'(random_32) : int'(random_64);
  endfunction

  function automatic int dut_wired(int i);
    return (i == 0) ? int'(wired_8) : (i == 1) ? int'(wired_32) : int'(wired_64);
  endfunction

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (random_32 !== 5'd31) begin
      errors++;
      $display("FAIL reset_random32: got %0d expected 31", random_32);
    end
    checks++;
    if (wired_32 !== 5'd0) begin
      errors++;
      $display("FAIL reset_wired32: got %0d expected 0", wired_32);
    end
    checks++;
    if (random_8 !== 3'd7 || random_64 !== 6'd63) begin
      errors++;
      $display("FAIL reset_random_8_64: got %0d/%0d expected 7/63", random_8, random_64);
    end
  endtask

  task automatic test_lcg();
    int exp_v [2] = '{10, 16};
    mode = 2'd0;
    for (int k = 0; k < 2; k++) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      checks++;
      if (random_32 !== 5'(exp_v[k])) begin
        errors++;
        $display("FAIL lcg_pulse%0d: got %0d expected %0d", k, random_32, exp_v[k]);
      end
    end
    tick();
    checks++;
    if (random_32 !== 5'd16) begin
      errors++;
      $display("FAIL lcg_hold: got %0d expected 16", random_32);
    end
  endtask

  task automatic test_wired_lcg();
    int bad;
    mode = 2'd0;
    wired_we = 1'b1;
    wired_in_w = 6'd30;
    tick();
    wired_we = 1'b0;
    checks++;
    if (random_32 !== 5'd31 || wired_32 !== 5'd30) begin
      errors++;
      $display("FAIL wired30_write: got random %0d wired %0d expected 31/30", random_32, wired_32);
    end
    bad = 0;
    next = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      checks++;
      if (random_32 !== 5'd30 && random_32 !== 5'd31) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL wired30_lcg_range: got %0d expected 30 or 31", random_32);
      end
    end
    next = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_v [4] = '{30, 31, 30, 31};
    mode = 2'd1;
    wired_we = 1'b1;
    wired_in_w = 6'd30;
    tick();
    wired_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      checks++;
      if (random_32 !== 5'(exp_v[k])) begin
        errors++;
        $display("FAIL rr_step%0d: got %0d expected %0d", k, random_32, exp_v[k]);
      end
    end
    tick();
    checks++;
    if (random_32 !== 5'd31) begin
      errors++;
      $display("FAIL rr_hold: got %0d expected 31", random_32);
    end
    // step down to 30 first so a missed override would be visible
    next = 1'b1;
    tick();
    wired_we = 1'b1;
    wired_in_w = 6'd8;
    tick();
    wired_we = 1'b0;
    next = 1'b0;
    checks++;
    if (random_32 !== 5'd31 || wired_32 !== 5'd8) begin
      errors++;
      $display("FAIL rr_wired_override: got random %0d wired %0d expected 31/8", random_32, wired_32);
    end
  endtask

  task automatic test_free_run();
    int exp_v [4] = '{30, 29, 31, 30};
    mode = 2'd2;
    next = 1'b1;
    wired_we = 1'b1;
    wired_in_w = 6'd29;
    tick();
    wired_we = 1'b0;
    checks++;
    if (random_32 !== 5'd31) begin
      errors++;
      $display("FAIL fr_start: got %0d expected 31", random_32);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (random_32 !== 5'(exp_v[k])) begin
        errors++;
        $display("FAIL fr_cycle%0d: got %0d expected %0d", k, random_32, exp_v[k]);
      end
    end
    next = 1'b0;
    tick();
    checks++;
    if (random_32 !== 5'd29) begin
      errors++;
      $display("FAIL fr_no_next: got %0d expected 29", random_32);
    end
  endtask

  task automatic test_seed();
    int exp_v [2] = '{10, 16};
    mode = 2'd0;
    wired_we = 1'b1;
    wired_in_w = 6'd0;
    tick();
    wired_we = 1'b0;
    next = 1'b1;
    repeat (5) tick();
    next = 1'b0;
    seed_we = 1'b1;
    seed_in = 18'h143fd;
    tick();
    seed_we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      checks++;
      if (random_32 !== 5'(exp_v[k])) begin
        errors++;
        $display("FAIL seed_reload%0d: got %0d expected %0d", k, random_32, exp_v[k]);
      end
    end
    // The third state of the sequence is 0x3C14F, which scales to 30; the
    // reload takes effect only for the following pulse.
    seed_we = 1'b1;
    seed_in = 18'h143fd;
    next = 1'b1;
    tick();
    seed_we = 1'b0;
    checks++;
    if (random_32 !== 5'd30) begin
      errors++;
      $display("FAIL seed_with_next_old: got %0d expected 30", random_32);
    end
    tick();
    next = 1'b0;
    checks++;
    if (random_32 !== 5'd10) begin
      errors++;
      $display("FAIL seed_with_next_new: got %0d expected 10", random_32);
    end
  endtask

  task automatic test_reset_override();
    mode = 2'd0;
    rst = 1'b1;
    next = 1'b1;
    seed_we = 1'b1;
    seed_in = 18'h3ffff;
    wired_we = 1'b1;
    wired_in_w = 6'd5;
    tick();
    rst = 1'b0;
    next = 1'b0;
    seed_we = 1'b0;
    wired_we = 1'b0;
    checks++;
    if (random_32 !== 5'd31 || wired_32 !== 5'd0) begin
      errors++;
      $display("FAIL rst_override: got random %0d wired %0d expected 31/0", random_32, wired_32);
    end
    next = 1'b1;
    tick();
    next = 1'b0;
    checks++;
    if (random_32 !== 5'd10) begin
      errors++;
      $display("FAIL rst_override_seed: got %0d expected 10", random_32);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      next = 1'($urandom_range(0, 1));
      wired_we = ($urandom_range(0, 19) == 0);
      // bias Wired towards the top so the single-entry range is exercised
      wired_in_w = ($urandom_range(0, 3) == 0) ? 6'h3f : 6'($urandom_range(0, 63));
      seed_we = ($urandom_range(0, 29) == 0);
      seed_in = 18'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      tick();
      for (int i = 0; i < 3; i++) begin
        int r;
        int w;
        r = dut_rand(i);
        w = dut_wired(i);
        checks++;
        if (r != m_rand[i] || w != m_wired[i] || w > r || r > ent[i] - 1) begin
          errors++;
          if (shown < 10)
            $display("FAIL random_e%0d cycle %0d: got random %0d wired %0d expected %0d/%0d",
                     ent[i], c, r, w, m_rand[i], m_wired[i]);
          shown++;
        end
      end
    end
    rst = 1'b0;
    next = 1'b0;
    wired_we = 1'b0;
    seed_we = 1'b0;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst = 1'b1;
    mode = 2'd0;
    next = 1'b0;
    wired_we = 1'b0;
    wired_in_w = '0;
    seed_we = 1'b0;
    seed_in = '0;
    @(negedge clk);
    test_reset();
    test_lcg();
    test_wired_lcg();
    test_round_robin();
    test_free_run();
    test_seed();
    test_reset_override();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
